bus_edge_monitor: RTL
=====================

# bus_edge_monitor

Synthesizable per-bit edge detector and event recorder for a multi-bit bus, the design-side counterpart of the `$rose`/`$sampled` checks used in our assertion benches. It samples a WIDTH-bit bus every clock, reports per-bit rise and fall masks, and tracks the LSB-only rise that `$rose` reports on a vector. Every non-zero edge event is pushed, with a timestamp, into a small FIFO that a consumer drains over a valid/ready handshake.

## Interface
- `WIDTH`, 4: monitored bus width (≥1).
- `TS_W`, 16: timestamp width.
- `DEPTH`, 8: event FIFO depth (power of two, ≥2).
- `CNT_W`, 8: width of the saturating counters.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `din` in WIDTH: monitored bus, synchronous to `clk`.
- `rise_o` out WIDTH: per-bit 0→1 mask for the last sample.
- `fall_o` out WIDTH: per-bit 1→0 mask for the last sample.
- `lsb_rose_o` out 1: equals `rise_o[0]` (vector `$rose` semantics).
- `lsb_rise_cnt_o` out CNT_W: saturating count of LSB rises.
- `evt_valid_o` out 1: FIFO head is valid.
- `evt_ready_i` in 1: consumer accepts the head.
- `evt_ts_o` out TS_W: head timestamp.
- `evt_rise_o` out WIDTH: head rise mask.
- `evt_fall_o` out WIDTH: head fall mask.
- `overflow_o` out 1: sticky flag; an event was dropped.
- `drop_cnt_o` out CNT_W: saturating count of dropped events.

## Operation
- Registers: `prev` (WIDTH), `primed` (1), free-running `ts` (TS_W), edge registers, counters, FIFO.
- Reset sets `primed`=0, `prev`=0, `ts`=0, `rise_o`/`fall_o`/`lsb_rose_o`=0, both counters=0, `overflow_o`=0, and empties the FIFO, so `evt_valid_o`=0.
- Priming state (`primed`=0): the first post-reset posedge loads `prev`←`din`, sets `primed`=1, and produces no edges or events. The prior value is undefined and is treated as no edge. This intentionally differs from the X→1 behaviour of `$rose`.
- Armed state (`primed`=1), each posedge:
  - `rise_o`←`din & ~prev`
  - `fall_o`←`~din & prev`
  - `prev`←`din`
- `lsb_rise_cnt_o` increments when the newly computed `rise[0]`=1 and saturates at 2^CNT_W−1.
- Event: when `(rise|fall)`≠0, push {`ts`, rise, fall}. `ts` is the counter value at the sampling edge.
- `ts` increments every cycle after reset and wraps to 0 modulo 2^TS_W. Events near the wrap carry the raw wrapped value.
- Push acceptance:
  - accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle (`evt_valid_o & evt_ready_i`);
  - otherwise the event is dropped: `overflow_o`←1 (cleared only by `rst`) and `drop_cnt_o`++ (saturating).
- Pop: the head advances when `evt_valid_o & evt_ready_i`. `evt_ready_i` is ignored while `evt_valid_o`=0.
- Head fields stay stable while `evt_valid_o`=1 and `evt_ready_i`=0.
- Push on empty while popping: not possible, because a pop needs valid.

## Timing
- `din` is sampled at posedge n. `rise_o`/`fall_o`/`lsb_rose_o` become valid after posedge n and hold for one cycle. Latency is 1 cycle; no combinational path from `din`.
- The event pushed at posedge n is visible at the FIFO head (`evt_valid_o`=1 when the FIFO was empty) after posedge n+1. Edge-to-valid latency is 2 cycles.
- Sustained throughput is one event per cycle.
- The counters update in the same cycle as `rise_o`.
- `rst` asserted mid-stream: outputs follow the reset values after that posedge. The cycle after release is the priming cycle.

## Structure
- Package `bus_edge_mon_pkg` holds:
  - the parameter defaults;
  - typedef `edge_evt_t` = struct {ts, rise, fall}, parameterised by localparams in the package;
  - helper function `sat_inc`.
- Sub-module `edge_evt_fifo`: synchronous single-clock FIFO of `edge_evt_t` with push/pop/full/empty and simultaneous push+pop when full. The top handles edge logic, counters, and the drop policy.

## Test plan
- Reset, then hold `din`=4'b0100, then apply `din`=4'b0101 at the 2nd sample → after the 3rd posedge `rise_o`=0001, `lsb_rose_o`=1, `lsb_rise_cnt_o`=1; one event {ts=1, rise=0001, fall=0000}.
- Toggle 0100/0101 every 10 time units (one clock) for 6 samples → `lsb_rose_o` pulses on alternating cycles, `lsb_rise_cnt_o`=3, and 5 events are queued with alternating rise=0001 / fall=0001. Then `din`=0000 → fall=0101 event.
- Priming check: first post-reset `din`=1111 → no edge and no event. Next `din`=0000 → fall=1111.
- Overflow: hold `evt_ready_i`=0, toggle `din`[0] for DEPTH+3 cycles → FIFO holds DEPTH events, `overflow_o`=1, `drop_cnt_o`=3. Repeat with `evt_ready_i`=1 while full → no drops.
- Backpressure: hold `evt_ready_i`=0 then release → head fields stable while stalled; events drain in order with increasing `ts`.
- Wrap and reset: with `TS_W`=4, an event at cycle 17 → `ts`=1. Assert `rst` mid-stream with 3 events queued → `evt_valid_o`=0 and counters=0 next cycle.

Source files
------------

// File: rtl/bus_edge_monitor_pkg.sv
// Shared types and defaults for the bus edge monitor.
//   WIDTH : monitored bus width
//   TS_W  : timestamp width
//   DEPTH : event FIFO depth (power of two, >= 2)
//   CNT_W : saturating counter width
package bus_edge_mon_pkg;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned TS_W  = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    // One recorded edge event: timestamp of the sampling edge plus both masks.
    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
    } edge_evt_t;

    // Priming discards the first sample after reset; armed compares against prev.
    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_ARMED = 1'b1
    } mon_state_e;

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/bus_edge_monitor_if.sv
// Bus/event signals of the edge monitor.
//   master : the monitor (samples din, drives edge masks, counters and FIFO head)
//   slave  : the environment (drives din and evt_ready_i, observes the rest)
interface bus_edge_monitor_if;
    import bus_edge_mon_pkg::*;

    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic             lsb_rose_o;
    logic [CNT_W-1:0] lsb_rise_cnt_o;
    logic             evt_valid_o;
    logic             evt_ready_i;
    logic [TS_W-1:0]  evt_ts_o;
    logic [WIDTH-1:0] evt_rise_o;
    logic [WIDTH-1:0] evt_fall_o;
    logic             overflow_o;
    logic [CNT_W-1:0] drop_cnt_o;

    modport master (
        input  din, evt_ready_i,
        output rise_o, fall_o, lsb_rose_o, lsb_rise_cnt_o,
               evt_valid_o, evt_ts_o, evt_rise_o, evt_fall_o,
               overflow_o, drop_cnt_o
    );

    modport slave (
        output din, evt_ready_i,
        input  rise_o, fall_o, lsb_rose_o, lsb_rise_cnt_o,
               evt_valid_o, evt_ts_o, evt_rise_o, evt_fall_o,
               overflow_o, drop_cnt_o
    );

endinterface

// File: rtl/bus_edge_monitor_fifo.sv
// Synchronous single-clock FIFO of edge_evt_t.
//   clk, rst    : clock, synchronous active-high reset
//   push_i      : write request (accepted when not full, or full with a pop)
//   push_data_i : event to write
//   pop_i       : read request (ignored while empty)
//   head_o      : oldest stored event
//   valid_o     : FIFO not empty
//   full_o      : FIFO holds DEPTH entries
module edge_evt_fifo
    import bus_edge_mon_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  edge_evt_t push_data_i,
    input  logic      pop_i,
    output edge_evt_t head_o,
    output logic      valid_o,
    output logic      full_o
);

    localparam int unsigned CNT_FW = PTR_W + 1;

    edge_evt_t         mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0] count_q, count_d;
    logic              valid_q, full_q;
    logic              do_push, do_pop;

    // Pointer/occupancy update; a pop frees the slot a same-cycle push needs.
    always_comb begin
        do_pop   = pop_i & valid_q;
        do_push  = push_i & (~full_q | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_FW'(1);
            2'b01:   count_d = count_q - CNT_FW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != '0);
            full_q   <= (count_d == CNT_FW'(DEPTH));
        end
    end

    // Storage needs no reset; occupancy flags qualify its contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = valid_q;
    assign full_o  = full_q;

endmodule

// File: rtl/bus_edge_monitor.sv
// Per-bit edge detector and timestamped event recorder for a WIDTH-bit bus.
//   clk, rst : clock, synchronous active-high reset
//   bus      : master modport - din in, rise/fall masks, LSB rise count,
//              event FIFO head with valid/ready, overflow flag and drop count
module bus_edge_monitor
    import bus_edge_mon_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    bus_edge_monitor_if.master bus
);

    mon_state_e       state_q, state_d;
    logic             sample_en;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [TS_W-1:0]  ts_q;
    logic [TS_W-1:0]  evt_ts_q;
    logic [CNT_W-1:0] lsb_cnt_q, lsb_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;
    logic             evt_pending, pop_evt, drop_evt;
    logic             fifo_valid, fifo_full;
    edge_evt_t        push_data, head;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one priming sample, then armed until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PRIME: state_d = ST_ARMED;
            ST_ARMED: state_d = ST_ARMED;
            default:  state_d = ST_PRIME;
        endcase
    end

    // State outputs: edges are only reported once prev holds a real sample
    always_comb begin
        sample_en = 1'b0;
        case (state_q)
            ST_ARMED: sample_en = 1'b1;
            default:  sample_en = 1'b0;
        endcase
    end

    // Edge detection, counters and drop policy
    always_comb begin
        prev_d = bus.din;
        rise_d = '0;
        fall_d = '0;
        if (sample_en) begin
            rise_d = bus.din & ~prev_q;
            fall_d = ~bus.din & prev_q;
        end
        lsb_cnt_d = rise_d[0] ? sat_inc(lsb_cnt_q) : lsb_cnt_q;

        // Registered masks are pushed one cycle after the sampling edge
        evt_pending    = |(rise_q | fall_q);
        push_data.ts   = evt_ts_q;
        push_data.rise = rise_q;
        push_data.fall = fall_q;
        pop_evt        = fifo_valid & bus.evt_ready_i;
        drop_evt       = evt_pending & fifo_full & ~pop_evt;
        overflow_d     = overflow_q | drop_evt;
        drop_cnt_d     = drop_evt ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            ts_q       <= '0;
            evt_ts_q   <= '0;
            lsb_cnt_q  <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            ts_q       <= ts_q + TS_W'(1);
            evt_ts_q   <= ts_q;
            lsb_cnt_q  <= lsb_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    edge_evt_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (evt_pending),
        .push_data_i (push_data),
        .pop_i       (pop_evt),
        .head_o      (head),
        .valid_o     (fifo_valid),
        .full_o      (fifo_full)
    );

    assign bus.rise_o         = rise_q;
    assign bus.fall_o         = fall_q;
    assign bus.lsb_rose_o     = rise_q[0];
    assign bus.lsb_rise_cnt_o = lsb_cnt_q;
    assign bus.evt_valid_o    = fifo_valid;
    assign bus.evt_ts_o       = head.ts;
    assign bus.evt_rise_o     = head.rise;
    assign bus.evt_fall_o     = head.fall;
    assign bus.overflow_o     = overflow_q;
    assign bus.drop_cnt_o     = drop_cnt_q;

endmodule
